// File: rtl/reg_file_wb_pkg.sv
// Shared constants and the write-buffer entry type for the register file.
package reg_file_wb_pkg;

  localparam int REG_ADDR_W      = 4;
  localparam int DATA_W          = 32;
  localparam logic [REG_ADDR_W-1:0] PC_ADDR = 4'hF;
  localparam int PC_STEP_DEFAULT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_entry_t;

endpackage

// File: rtl/reg_file_wb_fifo.sv
// Write-back FIFO; exposes all live entries oldest-first so the reader can forward.
module wb_fifo
  import reg_file_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wr_entry_t             push_entry_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output wr_entry_t             head_o,
  output wr_entry_t [DEPTH-1:0] ord_entry_o,
  output logic [DEPTH-1:0]      ord_vld_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage carries no reset; validity comes from the count alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord_entry_o[k] = mem_q[PTR_W'((int'(rd_ptr_q) + k) % DEPTH)];
      ord_vld_o[k]   = (k < int'(cnt_q));
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 16x32 register file with a buffered write-back port, read forwarding,
// PC auto-increment on R15 and an NZCV flag register.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] R_Addr_A,
  input  logic [REG_ADDR_W-1:0] R_Addr_B,
  input  logic [REG_ADDR_W-1:0] R_Addr_C,
  output logic [DATA_W-1:0]     R_Data_A,
  output logic [DATA_W-1:0]     R_Data_B,
  output logic [DATA_W-1:0]     R_Data_C,
  input  logic                  W_Valid,
  output logic                  W_Ready,
  input  logic [REG_ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0]     W_Data,
  input  logic                  S,
  input  logic [3:0]            NZCV_New,
  output logic [3:0]            NZCV,
  input  logic                  PC_Inc,
  input  logic                  Hold
);

  logic                  push, pop, full, empty;
  wr_entry_t             push_entry, head;
  wr_entry_t [DEPTH-1:0] ord_entry;
  logic [DEPTH-1:0]      ord_vld;

  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];
  logic [3:0]        nzcv_q, nzcv_d;

  // Ready is taken from registered fullness only, never from a same-cycle drain.
  assign W_Ready    = ~full;
  assign push       = W_Valid & ~full;
  assign pop        = ~Hold & ~empty;
  assign push_entry = '{addr: W_Addr, data: W_Data};

  wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .full_o       (full),
    .empty_o      (empty),
    .head_o       (head),
    .ord_entry_o  (ord_entry),
    .ord_vld_o    (ord_vld)
  );

  // A commit is applied after the PC step so a committed R15 wins.
  always_comb begin
    regs_d = regs_q;
    if (PC_Inc) regs_d[PC_ADDR] = regs_q[PC_ADDR] + DATA_W'(PC_STEP);
    if (pop)    regs_d[head.addr] = head.data;
    nzcv_d = S ? NZCV_New : nzcv_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      nzcv_q <= '0;
    end else begin
      regs_q <= regs_d;
      nzcv_q <= nzcv_d;
    end
  end

  // Entries are oldest-first, so the last match scanned is the newest.
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [REG_ADDR_W-1:0] a,
    input logic [DATA_W-1:0]     arr_val,
    input wr_entry_t [DEPTH-1:0] ent,
    input logic [DEPTH-1:0]      vld
  );
    fwd_read = arr_val;
    for (int k = 0; k < DEPTH; k++)
      if (vld[k] && ent[k].addr == a) fwd_read = ent[k].data;
  endfunction

  assign R_Data_A = fwd_read(R_Addr_A, regs_q[R_Addr_A], ord_entry, ord_vld);
  assign R_Data_B = fwd_read(R_Addr_B, regs_q[R_Addr_B], ord_entry, ord_vld);
  assign R_Data_C = fwd_read(R_Addr_C, regs_q[R_Addr_C], ord_entry, ord_vld);
  assign NZCV     = nzcv_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized and directed bench for reg_file_wb against a queue-based reference model.
module tb_reg_file_wb;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ra, rb, rc, wa, nzn;
  logic [31:0] wd;
  logic        wv, s, pci, hold;
  logic [31:0] R_Data_A, R_Data_B, R_Data_C;
  logic        W_Ready;
  logic [3:0]  NZCV;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mregs [16];
  logic [3:0]  mnz;

  always #5 clk = ~clk;

  reg_file_wb #(.DEPTH(DEPTH), .PC_STEP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .R_Addr_A (ra),
    .R_Addr_B (rb),
    .R_Addr_C (rc),
    .R_Data_A (R_Data_A),
    .R_Data_B (R_Data_B),
    .R_Data_C (R_Data_C),
    .W_Valid  (wv),
    .W_Ready  (W_Ready),
    .W_Addr   (wa),
    .W_Data   (wd),
    .S        (s),
    .NZCV_New (nzn),
    .NZCV     (NZCV),
    .PC_Inc   (pci),
    .Hold     (hold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return mq[i].d;
    return mregs[a];
  endfunction

  task automatic m_clear();
    mq.delete();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mnz = '0;
  endtask

  // Reference behaviour at a rising edge, from the architectural rules.
  task automatic m_edge();
    bit   acc, drn;
    ent_t e;
    if (rst) begin
      m_clear();
      return;
    end
    acc = wv && (mq.size() < DEPTH);
    drn = !hold && (mq.size() > 0);
    if (pci) mregs[15] = mregs[15] + 32'd4;
    if (drn) begin
      e = mq.pop_front();
      mregs[e.a] = e.d;
    end
    if (acc) mq.push_back('{a: wa, d: wd});
    if (s) mnz = nzn;
  endtask

  task automatic cmp_all();
    chk("rdA", R_Data_A, m_read(ra));
    chk("rdB", R_Data_B, m_read(rb));
    chk("rdC", R_Data_C, m_read(rc));
    chk("wready", {31'd0, W_Ready}, {31'd0, mq.size() < DEPTH});
    chk("nzcv", {28'd0, NZCV}, {28'd0, mnz});
  endtask

  task automatic step();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    m_clear();
    #1;
  endtask

  task automatic idle_inputs();
    wv = 0; wa = 0; wd = 0; s = 0; nzn = 0; pci = 0; hold = 0;
  endtask

  initial begin
    idle_inputs();
    ra = 0; rb = 7; rc = 15;
    rst = 1'b0;
    m_clear();
    #1;
    assert_rst();
    chk("rst_R0", R_Data_A, 32'h0);
    chk("rst_R7", R_Data_B, 32'h0);
    chk("rst_R15", R_Data_C, 32'h0);
    chk("rst_wready", {31'd0, W_Ready}, 32'h1);
    chk("rst_nzcv", {28'd0, NZCV}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Single write: forwarded next cycle, then committed.
    ra = 3; wv = 1; wa = 3; wd = 32'h12345678;
    step();
    wv = 0;
    chk("r3_fwd", R_Data_A, 32'h12345678);
    step();
    step();
    chk("r3_array", R_Data_A, 32'h12345678);
    chk("r3_ready", {31'd0, W_Ready}, 32'h1);

    // Fill under Hold, third request refused, then drain.
    ra = 1; hold = 1; wv = 1; wa = 1; wd = 32'hA;
    step();
    wd = 32'hB;
    step();
    chk("hold_full", {31'd0, W_Ready}, 32'h0);
    wd = 32'hC;
    step();
    wv = 0;
    chk("hold_r1", R_Data_A, 32'hB);
    step();
    chk("hold_keep", {31'd0, W_Ready}, 32'h0);
    hold = 0;
    step();
    step();
    chk("drain_ready", {31'd0, W_Ready}, 32'h1);
    chk("drain_r1", R_Data_A, 32'hB);

    // PC wrap, then a commit colliding with PC_Inc.
    rb = 15; wv = 1; wa = 15; wd = 32'hFFFFFFFC;
    step();
    wv = 0;
    step();
    pci = 1;
    step();
    pci = 0;
    chk("pc_wrap", R_Data_B, 32'h0);
    pci = 1;
    step();
    pci = 0;
    chk("pc_step", R_Data_B, 32'h4);
    wv = 1; wa = 15; wd = 32'h100;
    step();
    wv = 0; pci = 1;
    step();
    pci = 0;
    chk("pc_collide", R_Data_B, 32'h100);

    // Flags.
    s = 1; nzn = 4'b1010;
    step();
    s = 0; nzn = 4'b0101;
    step();
    chk("nzcv_hold", {28'd0, NZCV}, 32'hA);

    // Reset with pending entries.
    ra = 5; rb = 6; hold = 1; wv = 1; wa = 5; wd = 32'h55;
    step();
    wa = 6; wd = 32'h66;
    step();
    wv = 0;
    assert_rst();
    chk("rstd_r5", R_Data_A, 32'h0);
    chk("rstd_r6", R_Data_B, 32'h0);
    chk("rstd_ready", {31'd0, W_Ready}, 32'h1);
    step();
    rst = 0; hold = 0;
    step();
    step();
    chk("rstd_r5_after", R_Data_A, 32'h0);
    chk("rstd_r6_after", R_Data_B, 32'h0);

    // Random traffic, biased toward a few addresses to exercise forwarding.
    for (int n = 0; n < 600; n++) begin
      wv   = ($urandom_range(0, 9) < 7);
      wa   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      wd   = $urandom;
      hold = ($urandom_range(0, 9) < 3);
      pci  = ($urandom_range(0, 9) < 2);
      s    = ($urandom_range(0, 9) < 3);
      nzn  = 4'($urandom);
      ra   = 4'($urandom_range(0, 3));
      rb   = 4'($urandom_range(0, 15));
      rc   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) assert_rst();
      step();
      rst = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 Parameter DEPTH, default 2: number of write-buffer entries.
REQ-002 Parameter PC_STEP, default 4: R15 increment applied on PC_Inc.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 R_Addr_A, R_Addr_B, R_Addr_C  input  4 each  read-port register addresses.
REQ-006 R_Data_A, R_Data_B, R_Data_C  output  32 each  read data, combinational from address and current state.
REQ-007 W_Valid  input  1  write-back request carrying W_Addr/W_Data.
REQ-008 W_Ready  output  1  write buffer can accept; a transfer occurs when W_Valid and W_Ready are both high at a rising edge.
REQ-009 W_Addr  input  4  destination register; W_Data  input  32  result value (F).
REQ-010 S  input  1  flag-update enable; NZCV_New  input  4  new flags.
REQ-011 NZCV  output  4  stored condition flags.
REQ-012 PC_Inc  input  1  advance R15 by PC_STEP.
REQ-013 Hold  input  1  freezes buffer drain while high.

Function
REQ-014 Storage SHALL be 16 x 32-bit registers R0..R15 plus a FIFO write buffer of DEPTH entries {addr, data}.
REQ-015 W_Ready SHALL equal "buffer not full", registered-state-only; it SHALL NOT depend on a same-cycle drain.
REQ-016 On an accepted transfer, {W_Addr, W_Data} SHALL be appended at the FIFO tail.
REQ-017 When Hold is low and the buffer is non-empty, the head entry SHALL be written to the array and popped each cycle (1 commit/cycle).
REQ-018 Push and pop in the same cycle SHALL leave the count unchanged and both take effect.
REQ-019 Read ports SHALL forward: the newest buffered entry matching the address wins; otherwise array data.
REQ-020 Accepted data SHALL be visible on reads the cycle after acceptance (latency 1); the array update occurs no earlier than 1 cycle later.
REQ-021 PC_Inc SHALL add PC_STEP to array R15 modulo 2^32 (wraps 0xFFFFFFFC -> 0x00000000 for PC_STEP=4).
REQ-022 If a commit to R15 coincides with PC_Inc, the committed value SHALL be written and the increment dropped.
REQ-023 Forwarding of a pending R15 write SHALL take precedence over the array R15 value.
REQ-024 S high at an edge SHALL load NZCV_New into NZCV; S low holds NZCV; S is independent of W_Valid/W_Ready.
REQ-025 Writes to the same address in consecutive cycles SHALL commit in order; the later value is final.
REQ-026 Hold high with buffer full SHALL keep W_Ready low indefinitely; no entries lost or reordered.
REQ-027 Pointer and count arithmetic SHALL wrap modulo DEPTH; count width is clog2(DEPTH+1).

Reset
REQ-028 rst high SHALL immediately clear R0..R15 to 0, empty the buffer, and clear NZCV to 0, independent of clk.
REQ-029 During and after reset W_Ready SHALL be 1 and all R_Data outputs 0.
REQ-030 Reset asserted mid-drain SHALL discard all uncommitted entries; no partial commit.

Structure
REQ-031 Shared package SHALL hold REG_ADDR_W=4, DATA_W=32, PC_ADDR=4'hF, PC_STEP default, and the write-entry struct {addr, data}.
REQ-032 The write buffer SHALL be a sub-module named wb_fifo (DEPTH-parameterised, push/pop/full/empty plus per-entry visibility for forwarding).

Verification
REQ-033 Reset, then read R0/R7/R15 -> all 0, W_Ready=1, NZCV=0.
REQ-034 Write R3=0x12345678, Hold=0 -> R_Data_A(addr 3)=0x12345678 next cycle; array holds it after commit.
REQ-035 Hold=1, write R1=0xA, R1=0xB -> W_Ready=0 after second push; third W_Valid not accepted; read R1 returns 0xB; release Hold -> drains in 2 cycles, R1=0xB, W_Ready=1.
REQ-036 R15=0xFFFFFFFC, PC_Inc pulse -> R15=0x00000000; commit R15=0x100 with PC_Inc the same cycle -> R15=0x100.
REQ-037 S=1 NZCV_New=4'b1010 -> NZCV=1010; S=0 NZCV_New=4'b0101 -> NZCV remains 1010.
REQ-038 Hold=1, two entries buffered, assert rst -> buffer empty, targeted registers remain 0, W_Ready=1.
